// File: rtl/cnn_mem_pkg.sv
// Shared constants and dump-sequencer state encoding for the CNN SRAM responder.
package cnn_mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } dump_state_e;
endpackage

// File: rtl/cnn_sram_array.sv
// DEPTH x DATA_W storage: one write port, two registered write-first read ports.
module cnn_sram_array #(
  parameter int ADDR_W = cnn_mem_pkg::ADDR_W,
  parameter int DATA_W = cnn_mem_pkg::DATA_W,
  parameter int DEPTH  = cnn_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              en_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Array contents survive reset, so the write port has no reset branch
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read registers; a same-edge write to the read address wins over stale storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= {DATA_W{1'b0}};
      rdata_b <= {DATA_W{1'b0}};
    end else begin
      rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem_r[raddr_a];
      if (en_b) begin
        rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem_r[raddr_b];
      end
    end
  end
endmodule

// File: rtl/cnn_sram_responder.sv
// Memory-side responder for the CNN datapath: 1-cycle read port, write sink,
// host preload port and a valid/ready dump sequencer.
module cnn_sram_responder #(
  parameter int ADDR_W = cnn_mem_pkg::ADDR_W,
  parameter int DATA_W = cnn_mem_pkg::DATA_W,
  parameter int DEPTH  = cnn_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [ADDR_W-1:0] dut_sram_read_address,
  output logic [DATA_W-1:0] sram_dut_read_data,
  input  logic              dut_sram_write_enable,
  input  logic [ADDR_W-1:0] dut_sram_write_address,
  input  logic [DATA_W-1:0] dut_sram_write_data,
  input  logic              host_load_valid,
  output logic              host_load_ready,
  input  logic [ADDR_W-1:0] host_load_addr,
  input  logic [DATA_W-1:0] host_load_data,
  input  logic              host_dump_start,
  input  logic [ADDR_W-1:0] host_dump_base,
  input  logic [ADDR_W-1:0] host_dump_count,
  output logic              host_dump_valid,
  input  logic              host_dump_ready,
  output logic [ADDR_W-1:0] host_dump_addr,
  output logic [DATA_W-1:0] host_dump_data,
  output logic              host_dump_done,
  output logic [15:0]       dut_write_count
);
  import cnn_mem_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};

  dump_state_e       state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] remaining_r;
  logic              load_ready_s;
  logic              arr_we_s;
  logic [ADDR_W-1:0] arr_waddr_s;
  logic [DATA_W-1:0] arr_wdata_s;

  // Single write port: the datapath always wins, host loads only while idle
  always_comb begin
    load_ready_s = (state_r == IDLE) && !dut_sram_write_enable;
    arr_we_s     = 1'b0;
    arr_waddr_s  = host_load_addr;
    arr_wdata_s  = host_load_data;
    if (dut_sram_write_enable) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = dut_sram_write_address;
      arr_wdata_s = dut_sram_write_data;
    end else begin
      arr_we_s = host_load_valid && load_ready_s;
    end
  end

  assign host_load_ready = load_ready_s;

  cnn_sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset_b),
    .we      (arr_we_s),
    .waddr   (arr_waddr_s),
    .wdata   (arr_wdata_s),
    .raddr_a (dut_sram_read_address),
    .rdata_a (sram_dut_read_data),
    .en_b    (state_r == FETCH),
    .raddr_b (ptr_r),
    .rdata_b (host_dump_data)
  );

  // Dump sequencer: the data register only loads in FETCH, so it holds through PRESENT
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r         <= IDLE;
      ptr_r           <= ZERO_A;
      remaining_r     <= ZERO_A;
      host_dump_valid <= 1'b0;
      host_dump_addr  <= ZERO_A;
      host_dump_done  <= 1'b0;
    end else begin
      host_dump_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (host_dump_start) begin
            if (host_dump_count != ZERO_A) begin
              ptr_r       <= host_dump_base;
              remaining_r <= host_dump_count;
              state_r     <= FETCH;
            end else begin
              host_dump_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          host_dump_addr  <= ptr_r;
          host_dump_valid <= 1'b1;
          state_r         <= PRESENT;
        end
        PRESENT: begin
          if (host_dump_ready) begin
            host_dump_valid <= 1'b0;
            if (remaining_r != ONE_A) begin
              ptr_r       <= ptr_r + ONE_A;
              remaining_r <= remaining_r - ONE_A;
              state_r     <= FETCH;
            end else begin
              host_dump_done <= 1'b1;
              state_r        <= IDLE;
            end
          end
        end
        default: begin
          host_dump_valid <= 1'b0;
          state_r         <= IDLE;
        end
      endcase
    end
  end

  // Datapath write counter, free-running with 16-bit wrap
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dut_write_count <= 16'd0;
    end else if (dut_sram_write_enable) begin
      dut_write_count <= dut_write_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_cnn_sram_responder.sv
// Scoreboard bench for cnn_sram_responder: array-based memory model, randomized traffic.
module tb_cnn_sram_responder;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [11:0] dut_sram_read_address = 12'd0;
  logic [15:0] sram_dut_read_data;
  logic        dut_sram_write_enable = 1'b0;
  logic [11:0] dut_sram_write_address = 12'd0;
  logic [15:0] dut_sram_write_data = 16'd0;
  logic        host_load_valid = 1'b0;
  logic        host_load_ready;
  logic [11:0] host_load_addr = 12'd0;
  logic [15:0] host_load_data = 16'd0;
  logic        host_dump_start = 1'b0;
  logic [11:0] host_dump_base = 12'd0;
  logic [11:0] host_dump_count = 12'd0;
  logic        host_dump_valid;
  logic        host_dump_ready = 1'b0;
  logic [11:0] host_dump_addr;
  logic [15:0] host_dump_data;
  logic        host_dump_done;
  logic [15:0] dut_write_count;

  cnn_sram_responder dut (
    .clk(clk), .reset_b(reset_b),
    .dut_sram_read_address(dut_sram_read_address), .sram_dut_read_data(sram_dut_read_data),
    .dut_sram_write_enable(dut_sram_write_enable), .dut_sram_write_address(dut_sram_write_address),
    .dut_sram_write_data(dut_sram_write_data),
    .host_load_valid(host_load_valid), .host_load_ready(host_load_ready),
    .host_load_addr(host_load_addr), .host_load_data(host_load_data),
    .host_dump_start(host_dump_start), .host_dump_base(host_dump_base),
    .host_dump_count(host_dump_count), .host_dump_valid(host_dump_valid),
    .host_dump_ready(host_dump_ready), .host_dump_addr(host_dump_addr),
    .host_dump_data(host_dump_data), .host_dump_done(host_dump_done),
    .dut_write_count(dut_write_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] m_mem [4096];
  logic [15:0] m_cnt = 16'd0;
  logic [15:0] rd_q [$];
  logic [11:0] dump_q [$];
  int          done_exp = 0;
  logic        prev_valid = 1'b0;
  logic [11:0] held_addr = 12'd0;
  logic [15:0] held_data = 16'd0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock: the memory model takes this edge's write (datapath beats load), then
  // the read port must return the post-write contents one cycle later.
  task automatic tick();
    @(posedge clk);
    if (reset_b) begin
      if (dut_sram_write_enable) begin
        m_mem[dut_sram_write_address] = dut_sram_write_data;
        m_cnt = m_cnt + 16'd1;
      end else if (host_load_valid) begin
        m_mem[host_load_addr] = host_load_data;
      end
      rd_q.push_back(m_mem[dut_sram_read_address]);
    end
    #1;
  endtask

  task automatic random_dp(input logic [11:0] near);
    dut_sram_read_address  = ($urandom_range(0, 1) == 0) ? near + 12'($urandom_range(0, 3)) : 12'($urandom);
    dut_sram_write_enable  = ($urandom_range(0, 2) == 0);
    dut_sram_write_address = near + 12'($urandom_range(0, 3));
    dut_sram_write_data    = 16'($urandom);
  endtask

  // rmode 0: ready high; 1: random ready; 2: hold 6 cycles with a write to base in the window
  task automatic run_dump(input logic [11:0] base, input logic [11:0] cnt, input int rmode,
                          input logic traffic, output int first_done);
    int cyc;
    logic [11:0] a;
    host_load_valid = 1'b0;
    dut_sram_write_enable = 1'b0;
    host_dump_base  = base;
    host_dump_count = cnt;
    host_dump_start = 1'b1;
    host_dump_ready = (rmode == 0);
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 12'(i);
      dump_q.push_back(a);
    end
    done_exp++;
    tick();
    host_dump_start = 1'b0;
    first_done = -1;
    cyc = 0;
    while (done_exp != 0 && cyc < 30 * int'(cnt) + 20) begin
      cyc++;
      if (traffic) random_dp(base);
      else dut_sram_write_enable = 1'b0;
      case (rmode)
        0: host_dump_ready = 1'b1;
        1: host_dump_ready = ($urandom_range(0, 1) == 1);
        default: begin
          host_dump_ready = (cyc > 6);
          dut_sram_write_enable  = (cyc == 3);
          dut_sram_write_address = base;
          dut_sram_write_data    = 16'hDEAD;
        end
      endcase
      tick();
      if (host_dump_done && first_done < 0) first_done = cyc;
    end
    check("dump_done_wait", done_exp, 0);
    dut_sram_write_enable = 1'b0;
    host_dump_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  initial begin
    logic [11:0] ea;
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        prev_valid = 1'b0;
      end else begin
        if (rd_q.size() != 0) check("rd_data", sram_dut_read_data, rd_q.pop_front());
        check("wr_count", dut_write_count, m_cnt);
        if (host_load_valid) check("load_ready", host_load_ready, !dut_sram_write_enable);
        if (host_dump_valid && !prev_valid) begin
          if (dump_q.size() == 0) begin
            check("dump_unexpected_word", host_dump_valid, 1'b0);
          end else begin
            ea = dump_q.pop_front();
            check("dump_addr", host_dump_addr, ea);
            check("dump_data", host_dump_data, m_mem[ea]);
          end
          held_addr = host_dump_addr;
          held_data = host_dump_data;
        end else if (host_dump_valid) begin
          check("dump_addr_hold", host_dump_addr, held_addr);
          check("dump_data_hold", host_dump_data, held_data);
        end
        if (host_dump_done) begin
          check("done_expected", done_exp > 0, 1'b1);
          if (done_exp > 0) done_exp--;
        end
        prev_valid = host_dump_valid;
      end
    end
  end

  initial begin
    int fd;
    logic [15:0] pat [4];
    pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", sram_dut_read_data, 16'h0000);
    check("rst_dump_valid", host_dump_valid, 1'b0);
    check("rst_dump_addr", host_dump_addr, 12'h000);
    check("rst_dump_data", host_dump_data, 16'h0000);
    check("rst_dump_done", host_dump_done, 1'b0);
    check("rst_wr_count", dut_write_count, 16'h0000);
    check("rst_load_ready", host_load_ready, 1'b1);
    @(posedge clk);
    #1 reset_b = 1'b1;

    // Full preload, reading each address in the same cycle it is loaded
    for (int i = 0; i < 4096; i++) begin
      host_load_valid = 1'b1;
      host_load_addr  = 12'(i);
      host_load_data  = 16'($urandom);
      dut_sram_read_address = 12'(i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      host_load_addr = 12'(i);
      host_load_data = pat[i];
      tick();
    end
    host_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dut_sram_read_address = 12'(i);
      tick();
    end

    // Datapath write forwarded to a same-cycle read
    dut_sram_write_enable = 1'b1; dut_sram_write_address = 12'h010;
    dut_sram_write_data = 16'hBEEF; dut_sram_read_address = 12'h010;
    tick();
    dut_sram_write_enable = 1'b0;
    tick();

    // Load blocked by a datapath write, then accepted
    host_load_valid = 1'b1; host_load_addr = 12'h020; host_load_data = 16'h5A5A;
    dut_sram_write_enable = 1'b1; dut_sram_write_address = 12'h020;
    dut_sram_write_data = 16'hC3C3; dut_sram_read_address = 12'h020;
    tick();
    dut_sram_write_enable = 1'b0;
    tick();
    host_load_valid = 1'b0;
    tick();

    // Random mixed traffic over a narrow window to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      random_dp(12'h040);
      host_load_valid = ($urandom_range(0, 1) == 1);
      host_load_addr  = 12'h040 + 12'($urandom_range(0, 3));
      host_load_data  = 16'($urandom);
      tick();
    end
    host_load_valid = 1'b0;
    dut_sram_write_enable = 1'b0;

    run_dump(12'hFFE, 12'd3, 0, 1'b0, fd);
    check("dump_wrap_latency", fd, 6);
    run_dump(12'h000, 12'd0, 0, 1'b0, fd);
    run_dump(12'h100, 12'd2, 2, 1'b0, fd);
    for (int k = 0; k < 6; k++) begin
      run_dump(12'($urandom), 12'($urandom_range(1, 12)), 1, 1'b1, fd);
      repeat (2) tick();
    end

    // Asynchronous reset while a word is presented
    run_dump(12'h200, 12'd0, 0, 1'b0, fd);
    host_dump_base = 12'h200; host_dump_count = 12'd4; host_dump_start = 1'b1;
    dump_q.push_back(12'h200);
    done_exp++;
    tick();
    host_dump_start = 1'b0;
    repeat (3) tick();
    check("pre_rst_valid", host_dump_valid, 1'b1);
    reset_b = 1'b0;
    #1;
    check("midrst_valid", host_dump_valid, 1'b0);
    check("midrst_done", host_dump_done, 1'b0);
    check("midrst_count", dut_write_count, 16'h0000);
    dump_q.delete(); rd_q.delete(); done_exp = 0; m_cnt = 16'd0;
    @(posedge clk);
    #1 reset_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dut_sram_read_address = 12'h200 + 12'(i);
      tick();
    end
    dut_sram_read_address = 12'h003;
    repeat (4) tick();
    run_dump(12'h002, 12'd2, 1, 1'b1, fd);
    repeat (3) tick();
    check("dump_q_drained", dump_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
